// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared states, protocol bytes and controller register map for the UART debug master
package uart_dbg_pkg;
  typedef enum logic [2:0] {IDLE_POLL, POP, ARG_POLL, MEM, TX_POLL, TX_PUSH} state_e;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [1:0] REG_BAUD = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RX = 2'd2;
  localparam logic [1:0] REG_TX = 2'd3;
  localparam int ST_RX_VALID = 0;
  localparam int ST_RX_BUSY = 1;
  localparam int ST_TX_BUSY = 2;
  localparam int ST_RX_NE = 3;
  localparam int ST_TX_FULL = 4;
endpackage

// File: rtl/uart_dbg_timeout.sv
// uart_dbg_timeout: loadable down-counter, expires after Load enabled cycles following a clear
module uart_dbg_timeout #(
  parameter int unsigned Load = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(Load + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= W'(Load - 1);
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  assign expire_o = en_i && cnt_q == '0;
endmodule

// File: rtl/uart_dbg_master.sv
// uart_dbg_master: polls the UART controller for debug commands and runs single-word memory reads/writes
module uart_dbg_master
  import uart_dbg_pkg::*;
#(
  parameter int BusDataWidth = 32,
  parameter int UartDataWidth = 8,
  parameter int unsigned ByteTimeout = 50_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  output logic                    ctrl_wr_en_o,
  output logic [BusDataWidth-1:0] ctrl_addr_o,
  output logic [BusDataWidth-1:0] ctrl_wdata_o,
  input  logic [BusDataWidth-1:0] ctrl_rdata_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [BusDataWidth-1:0] mem_addr_o,
  output logic [BusDataWidth-1:0] mem_wdata_o,
  input  logic [BusDataWidth-1:0] mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);
  if (BusDataWidth != 32 || UartDataWidth != 8) begin : g_bad_cfg
    $error("uart_dbg_master supports only BusDataWidth=32 and UartDataWidth=8");
  end
  localparam int B = UartDataWidth;
  state_e state_q, state_d;
  logic [B-1:0] rx_byte;
  logic [BusDataWidth-1:0] addr_q, wdata_q, rsp_q;
  logic [3:0] cnt_q;
  logic [1:0] tx_cnt_q, tx_last_q;
  logic is_wr_q, err_q, err_d, op_ok, last_arg, expire, pop, push;
  logic [1:0] reg_sel;
  logic unused_rdata;
  assign unused_rdata = ^ctrl_rdata_i[BusDataWidth-1:B];
  assign rx_byte = ctrl_rdata_i[B-1:0];
  assign op_ok = rx_byte == OP_WRITE || rx_byte == OP_READ;
  assign last_arg = cnt_q == (is_wr_q ? 4'd8 : 4'd4);
  assign pop = state_q == POP && en_i;
  assign push = state_q == TX_PUSH && en_i;
  uart_dbg_timeout #(.Load(ByteTimeout)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == POP),
    .en_i     (en_i && state_q == ARG_POLL),
    .expire_o (expire)
  );
  always_comb begin
    state_d = state_q;
    reg_sel = REG_STATUS;
    ctrl_wr_en_o = 1'b0;
    mem_req_o = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE_POLL: state_d = ctrl_rdata_i[ST_RX_NE] ? POP : IDLE_POLL;
      POP: begin
        reg_sel = REG_RX;
        state_d = cnt_q == 4'd0 ? (op_ok ? ARG_POLL : TX_POLL) : (last_arg ? MEM : ARG_POLL);
        err_d = cnt_q == 4'd0 && !op_ok;
      end
      ARG_POLL: begin
        state_d = expire ? IDLE_POLL : (ctrl_rdata_i[ST_RX_NE] ? POP : ARG_POLL);
        err_d = expire;
      end
      MEM: begin
        mem_req_o = 1'b1;
        state_d = mem_ready_i ? (en_i ? TX_POLL : IDLE_POLL) : MEM;
      end
      TX_POLL: state_d = ctrl_rdata_i[ST_TX_FULL] ? TX_POLL : TX_PUSH;
      TX_PUSH: begin
        reg_sel = REG_TX;
        ctrl_wr_en_o = 1'b1;
        state_d = tx_cnt_q == tx_last_q ? IDLE_POLL : TX_POLL;
      end
      default: state_d = IDLE_POLL;
    endcase
    // Disabling parks the port at once, except an open memory handshake which must complete
    if (!en_i && state_q != MEM) begin
      state_d = IDLE_POLL;
      reg_sel = REG_STATUS;
      ctrl_wr_en_o = 1'b0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE_POLL;
      err_q <= 1'b0;
      is_wr_q <= 1'b0;
      cnt_q <= '0;
      tx_cnt_q <= '0;
      tx_last_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      if (pop) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          is_wr_q <= rx_byte == OP_WRITE;
          tx_last_q <= rx_byte == OP_READ ? 2'd3 : 2'd0;
          rsp_q <= BusDataWidth'(RSP_NAK);
        end else if (cnt_q <= 4'd4) addr_q <= {rx_byte, addr_q[BusDataWidth-1:B]};
        else wdata_q <= {rx_byte, wdata_q[BusDataWidth-1:B]};
      end
      if (state_q == MEM && mem_ready_i) rsp_q <= is_wr_q ? BusDataWidth'(RSP_ACK) : mem_rdata_i;
      if (push) begin
        rsp_q <= rsp_q >> B;
        tx_cnt_q <= tx_cnt_q + 2'd1;
      end
      if (state_d == IDLE_POLL) begin
        cnt_q <= '0;
        tx_cnt_q <= '0;
      end
    end
  end
  assign ctrl_addr_o = {{(BusDataWidth-2){1'b0}}, reg_sel};
  assign ctrl_wdata_o = {{(BusDataWidth-B){1'b0}}, rsp_q[B-1:0]};
  assign mem_we_o = is_wr_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o = state_q != IDLE_POLL;
  assign err_o = err_q;
endmodule

// File: tb/tb_uart_dbg_master.sv
// tb_uart_dbg_master: directed bench with a UART controller FIFO model and a latency-programmable memory
module tb_uart_dbg_master;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic en_i = 1'b1;
  logic tx_full = 1'b0;
  logic ctrl_wr_en_o, mem_req_o, mem_we_o, mem_ready_i, busy_o, err_o;
  logic [31:0] ctrl_addr_o, ctrl_wdata_o, ctrl_rdata_i, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h12345678;
  logic [7:0] rx_mem [0:63];
  logic [7:0] tx_log [0:31];
  int rx_wr = 0, rx_rd = 0, tx_n = 0, mem_n = 0, err_n = 0, req_cnt = 0, mem_lat = 0;
  int cyc = 0, ready_cyc = 0, push_cyc = 0, last_len = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic last_we = 1'b0, pop_bad = 1'b0, wr_full = 1'b0;
  logic rx_ne;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_dbg_master #(.BusDataWidth(32), .UartDataWidth(8), .ByteTimeout(100)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .ctrl_wr_en_o(ctrl_wr_en_o), .ctrl_addr_o(ctrl_addr_o), .ctrl_wdata_o(ctrl_wdata_o),
    .ctrl_rdata_i(ctrl_rdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  assign rx_ne = rx_wr != rx_rd;
  assign ctrl_rdata_i = ctrl_addr_o == 32'd1 ? {27'd0, tx_full, rx_ne, 3'b000} :
                        ctrl_addr_o == 32'd2 ? {24'd0, rx_mem[rx_rd[5:0]]} : 32'd0;
  assign mem_ready_i = mem_req_o && req_cnt == mem_lat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctrl_addr_o == 32'd2) begin
      if (!rx_ne) pop_bad <= 1'b1;
      else rx_rd <= rx_rd + 1;
    end
    if (ctrl_wr_en_o && ctrl_addr_o == 32'd3) begin
      tx_log[tx_n[4:0]] <= ctrl_wdata_o[7:0];
      tx_n <= tx_n + 1;
      push_cyc <= cyc;
      if (tx_full) wr_full <= 1'b1;
    end
    if (mem_req_o && mem_ready_i) begin
      mem_n <= mem_n + 1;
      last_addr <= mem_addr_o;
      last_wdata <= mem_wdata_o;
      last_we <= mem_we_o;
      last_len <= req_cnt + 1;
      ready_cyc <= cyc;
      req_cnt <= 0;
    end else req_cnt <= mem_req_o ? req_cnt + 1 : 0;
    if (err_o) err_n <= err_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_mem[rx_wr[5:0]] = b;
    rx_wr++;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 2000 && tx_n < n; i++) @(negedge clk);
    check("tx_count", tx_n, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy_o; i++) @(negedge clk);
    check("idle", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int n, e0, m0, t0;
    #1 rst_i = 1'b1;
    #1;
    check("rst_ctrl_addr", ctrl_addr_o, 32'd1);
    check("rst_wr_en", {31'd0, ctrl_wr_en_o}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    // write 0xDEADBEEF to 0x80000010, memory ready together with request
    send(8'h57); send_word(32'h80000010); send_word(32'hDEADBEEF);
    wait_tx(1);
    wait_idle();
    check("w_mem_n", mem_n, 1);
    check("w_addr", last_addr, 32'h80000010);
    check("w_data", last_wdata, 32'hDEADBEEF);
    check("w_we", {31'd0, last_we}, 32'd1);
    check("w_ack", {24'd0, tx_log[0]}, 32'h06);
    check("w_ack_latency", push_cyc - ready_cyc, 2);
    // read with three wait cycles
    mem_lat = 3;
    send(8'h52); send_word(32'h80000010);
    wait_tx(5);
    wait_idle();
    check("r_mem_n", mem_n, 2);
    check("r_we", {31'd0, last_we}, 32'd0);
    check("r_addr", last_addr, 32'h80000010);
    check("r_req_len", last_len, 4);
    check("r_b0", {24'd0, tx_log[1]}, 32'h78);
    check("r_b1", {24'd0, tx_log[2]}, 32'h56);
    check("r_b2", {24'd0, tx_log[3]}, 32'h34);
    check("r_b3", {24'd0, tx_log[4]}, 32'h12);
    // unknown opcode then a normal write
    mem_lat = 0;
    e0 = err_n;
    send(8'hAA);
    wait_tx(6);
    wait_idle();
    repeat (3) @(negedge clk);
    check("nak_byte", {24'd0, tx_log[5]}, 32'h15);
    check("nak_no_mem", mem_n, 2);
    check("nak_err_pulse", err_n - e0, 1);
    send(8'h57); send_word(32'h00000004); send_word(32'h44332211);
    wait_tx(7);
    wait_idle();
    check("w2_addr", last_addr, 32'h00000004);
    check("w2_data", last_wdata, 32'h44332211);
    check("w2_ack", {24'd0, tx_log[6]}, 32'h06);
    // read reply held off by a full TX FIFO
    tx_full = 1'b1;
    mem_rdata_i = 32'hCAFEF00D;
    send(8'h52); send_word(32'h00000020);
    for (int i = 0; i < 200 && mem_n < 4; i++) @(negedge clk);
    check("bp_mem_n", mem_n, 4);
    repeat (20) @(negedge clk);
    check("bp_held", tx_n, 7);
    check("bp_busy", {31'd0, busy_o}, 32'd1);
    tx_full = 1'b0;
    wait_tx(11);
    wait_idle();
    repeat (5) @(negedge clk);
    check("bp_total", tx_n, 11);
    check("bp_b0", {24'd0, tx_log[7]}, 32'h0D);
    check("bp_b1", {24'd0, tx_log[8]}, 32'hF0);
    check("bp_b2", {24'd0, tx_log[9]}, 32'hFE);
    check("bp_b3", {24'd0, tx_log[10]}, 32'hCA);
    check("bp_no_push_full", {31'd0, wr_full}, 32'd0);
    // stall mid-command: abort after 100 idle poll cycles
    e0 = err_n;
    m0 = mem_n;
    send(8'h57); send(8'h10);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ctrl_addr_o == 32'd2 && ctrl_rdata_i[7:0] == 8'h10) break;
    end
    n = 0;
    while (n < 300 && !err_o) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 101);
    check("to_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("to_err_pulse", err_n - e0, 1);
    check("to_no_reply", tx_n, 11);
    send(8'h57); send_word(32'h00000008); send_word(32'h00000001);
    wait_tx(12);
    wait_idle();
    check("to_w_mem_n", mem_n, m0 + 1);
    check("to_w_addr", last_addr, 32'h00000008);
    check("to_w_ack", {24'd0, tx_log[11]}, 32'h06);
    // disabled: bytes stay in the controller FIFO until re-enabled
    en_i = 1'b0;
    send(8'h57);
    repeat (10) @(negedge clk);
    check("en_off_no_pop", rx_wr - rx_rd, 1);
    check("en_off_idle", {31'd0, busy_o}, 32'd0);
    en_i = 1'b1;
    send_word(32'h0000000C); send_word(32'h55AA55AA);
    wait_tx(13);
    wait_idle();
    check("en_w_addr", last_addr, 32'h0000000C);
    check("en_w_data", last_wdata, 32'h55AA55AA);
    // asynchronous reset while a read is waiting on memory
    mem_lat = 1000;
    m0 = mem_n;
    t0 = tx_n;
    send(8'h52); send_word(32'h00000000);
    for (int i = 0; i < 200 && !mem_req_o; i++) @(negedge clk);
    check("rm_req_up", {31'd0, mem_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rm_req_drop", {31'd0, mem_req_o}, 32'd0);
    check("rm_ctrl_addr", ctrl_addr_o, 32'd1);
    check("rm_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    mem_lat = 0;
    repeat (20) @(negedge clk);
    check("rm_no_mem", mem_n, m0);
    check("rm_no_tx", tx_n, t0);
    check("no_empty_pop", {31'd0, pop_bad}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_dbg_master.md
Name: uart_dbg_master

Overview:
- Bus initiator that sits on the register interface of the UART controller.
- Polls the controller's RX side, parses a byte-serial debug command protocol, and executes single-word reads/writes on the system memory bus.
- Returns each result over the controller's TX register.
- Host debug/boot-load path into the RISC-V SoC; the only master of the UART controller register port when enabled.

Parameters:
BusDataWidth, 32, width of controller and memory data/address buses
UartDataWidth, 8, UART character width
ByteTimeout, 50_000_000, max clk_i cycles between command bytes before the parser aborts to IDLE

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  master enable; when 0, ctrl port held idle
ctrl_wr_en_o  out  1  controller register write strobe
ctrl_addr_o  out  BusDataWidth  controller register offset (bits[1:0] used, upper bits 0)
ctrl_wdata_o  out  BusDataWidth  controller write data
ctrl_rdata_i  in  BusDataWidth  controller read data, combinational same-cycle
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  BusDataWidth  word address
mem_wdata_o  out  BusDataWidth  write data
mem_rdata_i  in  BusDataWidth  read data, valid with mem_ready_i
mem_ready_i  in  1  memory completion
busy_o  out  1  command in progress (state not IDLE_POLL)
err_o  out  1  one-cycle pulse on NAK or timeout

Behaviour:
- Controller register map (decided): 0 baud cfg, 1 status, 2 RX data (read pops FIFO every cycle addressed), 3 TX data (write pushes).
- Status bits: [0] rx_valid, [1] rx_busy, [2] tx_busy, [3] rx_not_empty, [4] tx_full.
- Reset: all outputs 0 except ctrl_addr_o = 1 (status, side-effect free); state IDLE_POLL; shift regs 0.
- Idle ctrl port: ctrl_addr_o = 1, ctrl_wr_en_o = 0. Offset 2 is driven for exactly one cycle per byte consumed; offset 0 is never accessed.
- Protocol, multibyte fields little-endian:
  - 'W' (0x57), addr[4], data[4] -> memory write -> reply 0x06.
  - 'R' (0x52), addr[4] -> memory read -> reply rdata[4].
  - Any other opcode -> reply 0x15 (NAK) plus err_o pulse.
- States:
  - IDLE_POLL / ARG_POLL: sample status[3]. If 1, go POP next cycle.
  - POP: ctrl_addr_o = 2; capture ctrl_rdata_i[7:0] the same cycle; byte counter ++.
  - Opcode decode in IDLE path. Arguments shift in: 4 address bytes, then 4 data bytes for W.
  - MEM: mem_req_o = 1 with stable addr/we/wdata until the cycle mem_ready_i = 1. Read data latched that cycle. No memory timeout.
  - TX_POLL: status[4] = 0 -> TX_PUSH.
  - TX_PUSH: one cycle, ctrl_addr_o = 3, ctrl_wr_en_o = 1, wdata = {0, byte}. Reply counter ++. Return to TX_POLL until all reply bytes are sent (1 for W/NAK, 4 for R), then IDLE_POLL.
- Min latency: POP takes 2 cycles per byte (poll + pop). Mem write with ready in the same cycle as req -> first TX_PUSH 2 cycles after the mem_ready_i cycle.
- Timeout: counter clears on each POP; counts only in ARG_POLL. Reaching ByteTimeout -> IDLE_POLL, err_o pulse, no reply.
- en_i = 0: finish any in-flight MEM handshake (never drop mem_req_o early), then park in IDLE_POLL with a quiet ctrl port. Partial command is discarded.
- Async reset mid-operation: immediate return to reset values; mem_req_o drops asynchronously.
- Address/data widths: 4 bytes assembled into BusDataWidth; BusDataWidth = 32 is the only supported value (elaboration assert).

Decomposition:
- Package uart_dbg_pkg: state enum, opcode constants (0x57, 0x52), reply constants (0x06, 0x15), register offsets (0–3), status bit indices.
- Optional sub-module uart_dbg_timeout: loadable down-counter with clear, enable and expire pulse. Everything else stays in one FSM module.

Test Plan:
- Write: RX bytes 57 10 00 00 80 EF BE AD DE -> one mem write, addr 0x8000_0010, data 0xDEADBEEF, we = 1; single TX push 0x06.
- Read: RX 52 10 00 00 80, mem_rdata_i = 0x12345678, ready after 3 cycles -> mem_req_o high 4 cycles; TX pushes 78 56 34 12 in order.
- Bad opcode: RX 0xAA -> no mem_req_o; TX 0x15; err_o single pulse; next valid W command executes normally.
- Backpressure: status[4] = 1 for 20 cycles during an R reply -> no ctrl_wr_en_o while full; all 4 bytes sent after it clears, none lost or duplicated.
- Timeout: ByteTimeout = 100, send 57 10 then stall -> at cycle 100 err_o pulses, busy_o = 0; following full W succeeds.
- Reset mid-MEM: assert rst_i while mem_req_o = 1 -> mem_req_o = 0 and ctrl_addr_o = 1 immediately; after release, ctrl offset 2 is never driven without status[3] = 1.
